// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD add/subtract controller driving one shared combinational digit adder.
// Subtraction uses 9's complement + carry-in; negative results get a 10's-complement pass.
module bcd_addsub_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry,
    output logic                neg,
    output logic                err,
    output logic [3:0]          dig_a,
    output logic [3:0]          dig_b,
    output logic                dig_cin,
    input  logic [3:0]          dig_s,
    input  logic                dig_cout
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CALC, CORR, FIN} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          op_q;
    logic [IW-1:0] idx;
    logic          cy;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb begin
        dig_a   = 4'd0;
        dig_b   = 4'd0;
        dig_cin = 1'b0;
        unique case (state)
            CALC: begin
                dig_a   = a_q[4*int'(idx) +: 4];
                dig_b   = op_q ? 4'd9 - b_q[4*int'(idx) +: 4] : b_q[4*int'(idx) +: 4];
                dig_cin = cy;
            end
            // 9's complement of the stored digit plus the running carry yields 10's complement
            CORR: begin
                dig_a   = 4'd9 - result[4*int'(idx) +: 4];
                dig_cin = cy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            idx    <= '0;
            cy     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        err    <= 1'b0;
                        carry  <= 1'b0;
                        neg    <= 1'b0;
                        idx    <= '0;
                        cy     <= op;
                        result <= '0;
                        if (has_bad_digit(a) || has_bad_digit(b)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    result[4*int'(idx) +: 4] <= dig_s;
                    cy <= dig_cout;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (!op_q || dig_cout) begin
                            carry <= op_q ? 1'b0 : dig_cout;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            // No end-around carry: a < b, so re-complement the magnitude
                            neg   <= 1'b1;
                            cy    <= 1'b1;
                            state <= CORR;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CORR: begin
                    result[4*int'(idx) +: 4] <= dig_s;
                    cy <= dig_cout;
                    if (idx == LAST) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
